ip_codma_bus_arbiter: RTL

Shares the single CODMA memory master port between N_REQ requesters: the read machine, the write machine and, optionally, the descriptor/status fetch path. Round-robin arbitration per transaction; the winner owns the port from request through its last data beat. Sits between the per-function state machines and the memory bus in the CODMA top level. Tracks burst length from the transfer size code.

---
 rtl/ip_codma_pkg.sv | 26 ++
 rtl/ip_codma_rr_picker.sv | 34 +++
 rtl/ip_codma_bus_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ip_codma_pkg.sv
// Shared types and size-code helpers for the CODMA memory-port arbiter.
package ip_codma_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] SIZE_8B  = 4'd3;
  localparam logic [3:0] SIZE_16B = 4'd8;
  localparam logic [3:0] SIZE_32B = 4'd9;

  localparam int BEAT_W = 3;

  // Zero marks an illegal size code.
  function automatic logic [BEAT_W-1:0] size_to_beats(input logic [3:0] size);
    case (size)
      SIZE_8B:  return 3'd1;
      SIZE_16B: return 3'd2;
      SIZE_32B: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping at N_REQ.
module ip_codma_rr_picker #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N_REQ-1:0] w_req_dbl;
  logic [N_REQ-1:0]   w_req_rot;
  logic [IDX_W-1:0]   w_offset;
  logic [IDX_W:0]     w_sum;

  // Doubling the vector turns the wrap-around scan into a plain slice.
  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = w_req_dbl[ptr_i +: N_REQ];

  always_comb begin
    w_offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_offset = IDX_W'(k);
    end
  end

  assign w_sum   = {1'b0, ptr_i} + {1'b0, w_offset};
  assign valid_o = |req_i;
  assign idx_o   = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                                : w_sum[IDX_W-1:0];

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin owner of the single CODMA memory master port; the winner keeps
// the port from request through its last data beat.
module ip_codma_bus_arbiter
  import ip_codma_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    stop_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        wen_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*4-1:0]      size_i,
  input  logic [N_REQ*DATA_W-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        beat_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_wen_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [3:0]              mem_size_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_beat_i,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_error_i,
  output logic                    busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
  logic [3:0]        w_size_arr  [N_REQ];
  logic [DATA_W-1:0] w_wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign w_size_arr[gi]  = size_i[gi*4 +: 4];
      assign w_wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_t        r_state, w_state_next;
  logic [IDX_W-1:0]  r_ptr, w_ptr_next;
  logic [IDX_W-1:0]  r_owner, w_owner_next;
  logic              r_wen, w_wen_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [3:0]        r_size, w_size_next;
  logic [BEAT_W-1:0] r_len, w_len_next;
  logic [BEAT_W-1:0] r_cnt, w_cnt_next;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [N_REQ-1:0]  r_done, w_done_next;
  logic [N_REQ-1:0]  r_err, w_err_next;

  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [BEAT_W-1:0] w_pick_len;
  logic [IDX_W-1:0]  w_pick_inc;
  logic [IDX_W-1:0]  w_owner_inc;

  ip_codma_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req_i),
    .ptr_i   (r_ptr),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  assign w_pick_len  = size_to_beats(w_size_arr[w_pick_idx]);
  assign w_pick_inc  = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
  assign w_owner_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    w_wen_next   = r_wen;
    w_addr_next  = r_addr;
    w_size_next  = r_size;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    w_gnt_next   = '0;
    w_done_next  = '0;
    w_err_next   = '0;
    mem_req_o    = 1'b0;
    mem_wen_o    = 1'b0;
    mem_addr_o   = '0;
    mem_size_o   = '0;
    mem_wdata_o  = '0;
    beat_o       = '0;

    if (r_state == ARB_REQ) begin
      mem_req_o  = 1'b1;
      mem_wen_o  = r_wen;
      mem_addr_o = r_addr;
      mem_size_o = r_size;
    end
    if (r_state == ARB_DATA) begin
      beat_o[r_owner] = mem_beat_i;
      mem_wdata_o     = w_wdata_arr[r_owner];
    end

    // Stop outranks bus error, which outranks grant and final beat.
    if (stop_i) begin
      w_state_next = ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            w_owner_next = w_pick_idx;
            w_wen_next   = wen_i[w_pick_idx];
            w_addr_next  = w_addr_arr[w_pick_idx];
            w_size_next  = w_size_arr[w_pick_idx];
            w_len_next   = w_pick_len;
            if (w_pick_len != '0) begin
              w_state_next = ARB_REQ;
            end else begin
              w_err_next[w_pick_idx] = 1'b1;
              w_ptr_next             = w_pick_inc;
            end
          end
        end
        ARB_REQ: begin
          if (mem_error_i) begin
            w_state_next        = ARB_IDLE;
            w_err_next[r_owner] = 1'b1;
            w_ptr_next          = w_owner_inc;
          end else if (mem_gnt_i) begin
            w_state_next        = ARB_DATA;
            w_gnt_next[r_owner] = 1'b1;
            w_cnt_next          = '0;
          end else if (!req_i[r_owner]) begin
            w_state_next = ARB_IDLE;
          end
        end
        ARB_DATA: begin
          if (mem_error_i) begin
            w_state_next        = ARB_IDLE;
            w_err_next[r_owner] = 1'b1;
            w_ptr_next          = w_owner_inc;
          end else if (mem_beat_i) begin
            if (r_cnt == r_len - 3'd1) begin
              w_state_next         = ARB_IDLE;
              w_done_next[r_owner] = 1'b1;
              w_ptr_next           = w_owner_inc;
            end else begin
              w_cnt_next = r_cnt + 3'd1;
            end
          end
        end
        default: w_state_next = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
      r_wen   <= w_wen_next;
      r_addr  <= w_addr_next;
      r_size  <= w_size_next;
      r_len   <= w_len_next;
      r_cnt   <= w_cnt_next;
      r_gnt   <= w_gnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign gnt_o   = r_gnt;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign rdata_o = mem_rdata_i;
  assign busy_o  = (r_state != ARB_IDLE);

endmodule
